// File: rtl/uart_dump_pkg.sv
// Shared definitions for the RAM-to-UART dump arbiter: FSM state encoding and default widths.
package uart_dump_pkg;

    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DUMP_LEN   = 2704;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/uart_dump_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    logic [IDX_W:0] w_j;

    always_comb begin
        pick  = '0;
        index = '0;
        valid = 1'b0;
        w_j   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_j = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (w_j >= (IDX_W+1)'(N_REQ)) begin
                w_j = w_j - (IDX_W+1)'(N_REQ);
            end
            if (!valid && req[w_j[IDX_W-1:0]]) begin
                valid                 = 1'b1;
                index                 = w_j[IDX_W-1:0];
                pick[w_j[IDX_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_dump_arbiter.sv
// Round-robin arbiter sharing one RAM-to-UART dump engine among N_REQ RAM requesters.
// Optional watchdog abort enabled by defining UART_DUMP_ARB_WATCHDOG_EN.
module uart_dump_arbiter
    import uart_dump_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic                    busy,
    output logic [ADDR_W-1:0]       ram_addr,
    input  logic [N_REQ*DATA_W-1:0] ram_rdata,
    output logic                    eng_start,
    input  logic                    eng_end,
    input  logic [ADDR_W-1:0]       eng_addr,
    output logic [DATA_W-1:0]       eng_data
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic             r_start;
    logic             r_busy;

    logic [N_REQ-1:0] w_pick;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_timeout;
    logic [DATA_W-1:0] w_sel;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (r_ptr),
        .pick   (w_pick),
        .index  (w_idx),
        .valid  (w_any)
    );

    assign w_next_ptr = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + IDX_W'(1);

`ifdef UART_DUMP_ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [N_REQ-1:0] r_err;

    // Cycles spent in RUN; held at zero outside RUN so every grant starts fresh.
    always_ff @(posedge clk) begin
        if (reset || r_state != ST_RUN) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign err       = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = '0;
`endif

    // Grant sequencer: IDLE picks, RUN waits for end/abort, RELEASE waits for engine to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_DUMP_ARB_WATCHDOG_EN
            r_err   <= '0;
`endif
        end else begin
            r_done <= '0;
`ifdef UART_DUMP_ARB_WATCHDOG_EN
            r_err  <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_any && !eng_end) begin
                        r_gnt   <= w_pick;
                        r_idx   <= w_idx;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (eng_end || !req[r_idx] || w_timeout) begin
                        r_gnt   <= '0;
                        r_start <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_RELEASE;
                        if (eng_end) begin
                            r_done <= r_gnt;
                        end
`ifdef UART_DUMP_ARB_WATCHDOG_EN
                        else if (w_timeout) begin
                            r_err <= r_gnt;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!eng_end) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_sel     = ram_rdata[r_idx*DATA_W +: DATA_W];
    assign eng_data  = (|r_gnt) ? w_sel : '0;
    assign ram_addr  = eng_addr;
    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign eng_start = r_start;

endmodule

// File: tb/tb_uart_dump_arbiter.sv
// Self-checking bench for uart_dump_arbiter; watchdog scenario runs when UART_DUMP_ARB_WATCHDOG_EN is defined.
module tb_uart_dump_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  gnt, done, err;
    logic        busy;
    logic [14:0] ram_addr;
    logic [31:0] ram_rdata = '0;
    logic        eng_start;
    logic        eng_end = 1'b0;
    logic [14:0] eng_addr = '0;
    logic [7:0]  eng_data;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    uart_dump_arbiter #(
        .N_REQ       (4),
        .ADDR_W      (15),
        .DATA_W      (8),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .eng_start (eng_start),
        .eng_end   (eng_end),
        .eng_addr  (eng_addr),
        .eng_data  (eng_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Reference round-robin choice: first requester at or after ptr, modulo 4.
    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; eng_end = 1'b0;
        tick(); tick();
        reset = 1'b0;
        m_ptr = 0;
    endtask

    task automatic finish_dump();
        eng_end = 1'b1; tick();
        eng_end = 1'b0; req = '0; tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (done !== 4'b0 || err !== 4'b0) begin n_fail++; $display("FAIL reset_pulses: done %b err %b want 0000", done, err); end
        n_checks++; if (eng_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_busy: start %b busy %b want 0 0", eng_start, busy); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; tick();
        n_checks++; if (gnt !== 4'b0001 || eng_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: gnt %b start %b busy %b want 0001 1 1", gnt, eng_start, busy); end
        repeat (29) tick();
        n_checks++; if (gnt !== 4'b0001 || done !== 4'b0) begin n_fail++; $display("FAIL single_hold: gnt %b done %b want 0001 0000", gnt, done); end
        eng_end = 1'b1; tick();
        n_checks++; if (done !== 4'b0001 || gnt !== 4'b0 || eng_start !== 1'b0) begin n_fail++; $display("FAIL single_done: done %b gnt %b start %b want 0001 0000 0", done, gnt, eng_start); end
        eng_end = 1'b0; req = '0; tick();
        n_checks++; if (done !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: done %b busy %b want 0000 0", done, busy); end
    endtask

    task automatic test_contention();
        int pulses = 0;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            pulses += $countones(done);
            n_checks++; if (gnt !== (4'b0001 << (n % 4))) begin n_fail++; $display("FAIL contention_order%0d: gnt %b want %b", n, gnt, 4'b0001 << (n % 4)); end
            repeat (9) begin tick(); pulses += $countones(done); end
            eng_end = 1'b1; tick();
            pulses += $countones(done);
            n_checks++; if (done !== (4'b0001 << (n % 4))) begin n_fail++; $display("FAIL contention_done%0d: done %b want %b", n, done, 4'b0001 << (n % 4)); end
            eng_end = 1'b0; tick();
            pulses += $countones(done);
            n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL contention_gap%0d: gnt %b want 0000", n, gnt); end
        end
        req = '0; tick(); tick();
        pulses += $countones(done);
        n_checks++; if (pulses != 5) begin n_fail++; $display("FAIL contention_pulses: got %0d want 5", pulses); end
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0100; tick();
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_grant: gnt %b want 0100", gnt); end
        req = 4'b1101; repeat (4) tick();
        req = 4'b1001; tick();
        n_checks++; if (eng_start !== 1'b0 || gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_drop: start %b gnt %b done %b busy %b want 0 0000 0000 1", eng_start, gnt, done, busy); end
        tick();
        n_checks++; if (gnt !== 4'b0 || busy !== 1'b0 || done !== 4'b0) begin n_fail++; $display("FAIL abort_release: gnt %b busy %b done %b want 0000 0 0000", gnt, busy, done); end
        tick();
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL abort_next: gnt %b want 1000", gnt); end
        finish_dump();
    endtask

    task automatic test_data_steer();
        do_reset();
        ram_rdata = 32'hD3C2B1A0; eng_addr = 15'h0A90; tick();
        n_checks++; if (eng_data !== 8'h00) begin n_fail++; $display("FAIL steer_idle: eng_data %h want 00", eng_data); end
        n_checks++; if (ram_addr !== 15'h0A90) begin n_fail++; $display("FAIL steer_addr: ram_addr %h want 0a90", ram_addr); end
        req = 4'b0100; tick();
        n_checks++; if (gnt !== 4'b0100 || eng_data !== 8'hC2) begin n_fail++; $display("FAIL steer_gnt2: gnt %b eng_data %h want 0100 c2", gnt, eng_data); end
        finish_dump();
        n_checks++; if (eng_data !== 8'h00) begin n_fail++; $display("FAIL steer_after: eng_data %h want 00", eng_data); end
    endtask

    task automatic test_stale_end();
        do_reset();
        eng_end = 1'b1; req = 4'b0001; tick(); tick();
        n_checks++; if (gnt !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stale_hold: gnt %b busy %b want 0000 0", gnt, busy); end
        eng_end = 1'b0; tick();
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL stale_grant: gnt %b want 0001", gnt); end
        finish_dump();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        req = 4'b0001; tick(); repeat (3) tick();
        reset = 1'b1; tick();
        n_checks++; if (gnt !== 4'b0 || eng_start !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin n_fail++; $display("FAIL midrst_clear: gnt %b start %b busy %b done %b want 0000 0 0 0000", gnt, eng_start, busy, done); end
        reset = 1'b0; m_ptr = 0; req = 4'b0010; tick();
        n_checks++; if (gnt !== 4'b0010 || eng_start !== 1'b1) begin n_fail++; $display("FAIL midrst_fresh: gnt %b start %b want 0010 1", gnt, eng_start); end
        finish_dump();
    endtask

    task automatic test_random();
        logic [3:0]  r, r2;
        logic [31:0] rd;
        logic [7:0]  exp_data;
        int e, dur, mode, hold;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            r  = 4'($urandom_range(1, 15));
            e  = rr_model(r, m_ptr);
            rd = $urandom;
            exp_data  = 8'(rd >> (8 * e));
            req = r; ram_rdata = rd; eng_addr = 15'($urandom);
            tick();
            n_checks++; if (gnt !== (4'b0001 << e) || eng_start !== 1'b1) begin n_fail++; $display("FAIL rand_grant%0d: gnt %b start %b want %b 1", it, gnt, eng_start, 4'b0001 << e); end
            n_checks++; if (eng_data !== exp_data || ram_addr !== eng_addr) begin n_fail++; $display("FAIL rand_data%0d: data %h addr %h want %h %h", it, eng_data, ram_addr, exp_data, eng_addr); end
            dur = $urandom_range(0, 6);
            repeat (dur) tick();
            mode = $urandom_range(0, 2);
            if (mode != 1) eng_end = 1'b1;
            if (mode != 0) begin r2 = req; r2[e] = 1'b0; req = r2; end
            tick();
            n_checks++; if (gnt !== 4'b0 || eng_start !== 1'b0 || err !== 4'b0 || done !== ((mode != 1) ? (4'b0001 << e) : 4'b0)) begin
                n_fail++; $display("FAIL rand_end%0d: gnt %b start %b done %b err %b mode %0d want 0000 0 %b 0000", it, gnt, eng_start, done, err, mode, (mode != 1) ? (4'b0001 << e) : 4'b0);
            end
            m_ptr = (e + 1) % 4;
            hold = (mode != 1) ? $urandom_range(0, 2) : 0;
            for (int h = 0; h < hold; h++) begin
                tick();
                n_checks++; if (busy !== 1'b1 || gnt !== 4'b0 || done !== 4'b0) begin n_fail++; $display("FAIL rand_release%0d: busy %b gnt %b done %b want 1 0000 0000", it, busy, gnt, done); end
            end
            eng_end = 1'b0; tick();
            n_checks++; if (busy !== 1'b0 || done !== 4'b0 || gnt !== 4'b0) begin n_fail++; $display("FAIL rand_idle%0d: busy %b done %b gnt %b want 0 0000 0000", it, busy, done, gnt); end
        end
        req = '0; tick(); tick();
    endtask

`ifdef UART_DUMP_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        do_reset();
        req = 4'b0001; tick();
        repeat (49) tick();
        n_checks++; if (err !== 4'b0 || eng_start !== 1'b1) begin n_fail++; $display("FAIL wdog_before: err %b start %b want 0000 1", err, eng_start); end
        tick();
        n_checks++; if (err !== 4'b0001 || eng_start !== 1'b0 || done !== 4'b0) begin n_fail++; $display("FAIL wdog_fire: err %b start %b done %b want 0001 0 0000", err, eng_start, done); end
        req = '0; tick();
        n_checks++; if (err !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wdog_idle: err %b busy %b want 0000 0", err, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_data_steer();
        test_stale_end();
        test_reset_mid_run();
        test_random();
`ifdef UART_DUMP_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_dump_arbiter.md
Name: uart_dump_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one RAM-to-UART dump engine among N_REQ RAM requesters.
- Each requester owns a byte-wide RAM and raises a level request.
- The arbiter grants one requester and drives the engine's level start / end handshake.
- While a requester holds the grant, the engine's address goes to all RAMs and the granted RAM's read data is steered back to the engine.
- It sits between the per-RAM capture logic and the single dump engine / UART transmitter.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 15, RAM address width
- DATA_W, 8, RAM data width
- TIMEOUT_CYC, 2000000, watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  level request per requester; held until done or abort
- gnt  out  N_REQ  one-hot grant, registered
- done  out  N_REQ  one-cycle pulse when the granted dump completes
- err  out  N_REQ  one-cycle pulse on watchdog abort (tied 0 when the feature is off)
- busy  out  1  high whenever state != IDLE
- ram_addr  out  ADDR_W  broadcast address to all RAMs (= eng_addr)
- ram_rdata  in  N_REQ*DATA_W  concatenated RAM read data; requester i occupies [i*DATA_W +: DATA_W]
- eng_start  out  1  level start to the dump engine
- eng_end  in  1  engine completion flag; held high until eng_start drops
- eng_addr  in  ADDR_W  engine RAM address
- eng_data  out  DATA_W  granted RAM data to engine; 0 when no grant

Behaviour:
- Reset, synchronous active-high on rising clk edge:
  - gnt=0, done=0, err=0, eng_start=0, busy=0
  - state=IDLE, rr_ptr=0 (requester 0 has highest priority first)
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Next cycle: gnt[i]=1, eng_start=1, state=RUN. Latency from req to gnt/eng_start is 1 cycle.
- RUN:
  - If eng_end=1: next cycle eng_start=0, gnt=0, done[i]=1 for one cycle, rr_ptr=(i+1) mod N_REQ, state=RELEASE.
  - If req[i] drops while eng_end=0 (abort): next cycle eng_start=0, gnt=0, no done pulse, rr_ptr=(i+1) mod N_REQ, state=RELEASE.
  - If eng_end=1 and req[i]=0 in the same cycle: completion wins and done[i] pulses.
- RELEASE:
  - Stay while eng_end=1, i.e. wait for the engine to clear.
  - When eng_end=0, go to IDLE. The earliest next grant is 2 cycles after the done pulse.
  - Requests arriving in RUN or RELEASE wait; none are lost, because req is a level.
- Datapath, combinational:
  - ram_addr = eng_addr.
  - eng_data = ram_rdata slice of the granted index, or 0 when gnt == 0.
- Fairness: with all req high, grants cycle 0,1,2,3,0,… No requester waits more than N_REQ-1 dumps.
- A requester whose req stays high after done is re-queued normally; it is not granted back-to-back while others are requesting.
- gnt is always one-hot or zero; eng_start=1 if and only if state=RUN.
- If eng_end=1 in IDLE (stale), ignore it and do not grant until eng_end=0.

Optional Feature:
- Macro: UART_DUMP_ARB_WATCHDOG_EN.
- With the macro defined:
  - A cycle counter is cleared on entry to RUN and increments while in RUN.
  - If it reaches TIMEOUT_CYC-1 with eng_end=0, abort as for a dropped req, and pulse err[i] for one cycle instead of done.
- Without the macro:
  - No counter logic is built.
  - err is driven constant 0.
  - RUN waits indefinitely.

Decomposition:
- Shared package uart_dump_pkg holds:
  - State encoding constants ST_IDLE=0, ST_RUN=1, ST_RELEASE=2 (2-bit)
  - Default ADDR_W/DATA_W
  - DUMP_LEN constant 2704
- One natural sub-module, rr_pick: combinational round-robin selector. Inputs req and rr_ptr; outputs one-hot pick and index.

Test Plan:
- Single request: req=0001, engine asserts eng_end 30 cycles after start → gnt=0001 and eng_start 1 cycle after req; done[0] pulses 1 cycle after eng_end; gnt=0.
- Contention: req=1111 held, engine ends each dump after 10 cycles → grant order 0,1,2,3,0; exactly one done pulse per dump.
- Abort: req[2] drops 5 cycles into RUN → eng_start=0 next cycle, no done[2], rr_ptr=3; pending req[3] is granted after RELEASE.
- Data steering: ram_rdata = {8'hD3,8'hC2,8'hB1,8'hA0}, gnt=0100 → eng_data=8'hC2; with no grant eng_data=0; ram_addr tracks eng_addr=15'h0A90.
- Reset mid-RUN: assert reset for 1 cycle during a dump → next cycle gnt=0, eng_start=0, busy=0; after release, req=0010 is granted fresh.
- Watchdog (macro on, TIMEOUT_CYC=50): eng_end never rises → err[i] pulses at cycle 50 of RUN, eng_start drops, then IDLE.
